// File: rtl/reg_lcd_display.sv
// reg_lcd_display: renders register snapshot x0..x7 as hex on a 16x2 HD44780 LCD in 8-bit mode.
// Write-only: power-on init, strobe timing and periodic refresh are all counter-timed.
module reg_lcd_display #(
    parameter int unsigned INIT_WAIT = 750000,
    parameter int unsigned EN_CYCLES = 25,
    parameter int unsigned CMD_WAIT  = 2500,
    parameter int unsigned CLR_WAIT  = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] x0,
    input  logic [7:0] x1,
    input  logic [7:0] x2,
    input  logic [7:0] x3,
    input  logic [7:0] x4,
    input  logic [7:0] x5,
    input  logic [7:0] x6,
    input  logic [7:0] x7,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on,
    output logic       init_done,
    output logic       frame_done
);

    localparam int unsigned MAX_A   = (INIT_WAIT > CLR_WAIT) ? INIT_WAIT : CLR_WAIT;
    localparam int unsigned MAX_B   = (CMD_WAIT > EN_CYCLES) ? CMD_WAIT : EN_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_FRAME_START,
        ST_LINE_ADDR,
        ST_CHAR
    } state_e;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_PULSE,
        PH_WAIT
    } phase_e;

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  wait_len;
    logic [1:0]        idx_q, idx_d;
    logic              line_q, line_d;
    logic [3:0]        chr_q, chr_d;
    logic [7:0][7:0]   snap_q, snap_d;
    logic              init_done_q, init_done_d;
    logic              frame_done_q, frame_done_d;
    logic              en_q, en_d;
    logic              rs_q, rs_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        wr_byte;
    logic              wr_rs;
    logic [7:0]        sel_byte;
    logic [3:0]        nibble;
    logic              is_wr;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        hex_ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Sequencer: main state plus SETUP/PULSE/WAIT phase of the current write
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        line_d      = line_q;
        chr_d       = chr_q;
        snap_d      = snap_q;
        init_done_d = init_done_q;
        wait_len    = (state_q == ST_INIT && idx_q == 2'd3) ? CNT_W'(CLR_WAIT) : CNT_W'(CMD_WAIT);

        case (state_q)
            ST_PWR_WAIT: begin
                if (cnt_q == CNT_W'(INIT_WAIT)) begin
                    state_d = ST_INIT;
                    phase_d = PH_SETUP;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FRAME_START: begin
                snap_d  = {x7, x6, x5, x4, x3, x2, x1, x0};
                state_d = ST_LINE_ADDR;
                phase_d = PH_SETUP;
                line_d  = 1'b0;
                cnt_d   = '0;
            end
            default: begin
                case (phase_q)
                    PH_SETUP: begin
                        phase_d = PH_PULSE;
                        cnt_d   = '0;
                    end
                    PH_PULSE: begin
                        if (cnt_q == CNT_W'(EN_CYCLES - 1)) begin
                            phase_d = PH_WAIT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    PH_WAIT: begin
                        if (cnt_q == wait_len - CNT_W'(1)) begin
                            cnt_d   = '0;
                            phase_d = PH_SETUP;
                            case (state_q)
                                ST_INIT: begin
                                    if (idx_q == 2'd3) begin
                                        state_d     = ST_FRAME_START;
                                        init_done_d = 1'b1;
                                    end else begin
                                        idx_d = idx_q + 2'd1;
                                    end
                                end
                                ST_LINE_ADDR: begin
                                    state_d = ST_CHAR;
                                    chr_d   = 4'd0;
                                end
                                ST_CHAR: begin
                                    if (chr_q == 4'd15) begin
                                        if (!line_q) begin
                                            state_d = ST_LINE_ADDR;
                                            line_d  = 1'b1;
                                        end else begin
                                            state_d = ST_FRAME_START;
                                        end
                                    end else begin
                                        chr_d = chr_q + 4'd1;
                                    end
                                end
                                default: ;
                            endcase
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: phase_d = PH_SETUP;
                endcase
            end
        endcase
    end

    // Byte and register-select for the write about to enter SETUP
    always_comb begin
        sel_byte = snap_q[{line_d, chr_d[3:2]}];
        nibble   = chr_d[0] ? sel_byte[3:0] : sel_byte[7:4];
        wr_rs    = 1'b0;
        wr_byte  = 8'h00;
        case (state_d)
            ST_INIT: begin
                case (idx_d)
                    2'd0:    wr_byte = 8'h38;
                    2'd1:    wr_byte = 8'h0C;
                    2'd2:    wr_byte = 8'h06;
                    default: wr_byte = 8'h01;
                endcase
            end
            ST_LINE_ADDR: wr_byte = line_d ? 8'hC0 : 8'h80;
            ST_CHAR: begin
                wr_rs   = 1'b1;
                wr_byte = chr_d[1] ? 8'h20 : hex_ascii(nibble);
            end
            default: ;
        endcase
    end

    // Output next-values; rs/data load only on entry to SETUP so they hold through PULSE and WAIT
    always_comb begin
        is_wr        = (state_d == ST_INIT) || (state_d == ST_LINE_ADDR) || (state_d == ST_CHAR);
        en_d         = is_wr && (phase_d == PH_PULSE);
        rs_d         = rs_q;
        data_d       = data_q;
        frame_done_d = 1'b0;
        if (is_wr && phase_d == PH_SETUP) begin
            rs_d   = wr_rs;
            data_d = wr_byte;
        end
        if (state_q == ST_CHAR && line_q && chr_q == 4'd15 &&
            phase_d == PH_WAIT && cnt_d == CNT_W'(CMD_WAIT - 1)) begin
            frame_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_PWR_WAIT;
            phase_q      <= PH_SETUP;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            line_q       <= 1'b0;
            chr_q        <= 4'd0;
            snap_q       <= '0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            en_q         <= 1'b0;
            rs_q         <= 1'b0;
            data_q       <= 8'h00;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            line_q       <= line_d;
            chr_q        <= chr_d;
            snap_q       <= snap_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
            en_q         <= en_d;
            rs_q         <= rs_d;
            data_q       <= data_d;
        end
    end

    assign lcd_data   = data_q;
    assign lcd_rs     = rs_q;
    assign lcd_en     = en_q;
    assign lcd_rw     = 1'b0;
    assign lcd_on     = 1'b1;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_reg_lcd_display.sv
// tb_reg_lcd_display: power-on sequence, frame content against a string-based display model,
// snapshot behaviour, strobe protocol monitor and asynchronous reset mid-pulse.
module tb_reg_lcd_display;

    localparam int IW  = 4;
    localparam int ENC = 2;
    localparam int CW  = 3;
    localparam int CLW = 6;
    localparam int WP  = 1 + ENC + CW;
    localparam int FB  = 34 * WP;
    localparam int FP  = 1 + FB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] xr [8];
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_on, init_done, frame_done;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         rise;
    } wr_t;

    wr_t        wq[$];
    int         fdq[$];
    int         id_rise = -1;
    logic       pen = 1'b0, pid = 1'b0, prs = 1'b0, lrs = 1'b0;
    logic [7:0] pdata = 8'h00, ldata = 8'h00;
    int         rise_c = 0;

    always #5 clk = ~clk;

    reg_lcd_display #(
        .INIT_WAIT(IW), .EN_CYCLES(ENC), .CMD_WAIT(CW), .CLR_WAIT(CLW)
    ) dut (
        .clk(clk), .rst(rst),
        .x0(xr[0]), .x1(xr[1]), .x2(xr[2]), .x3(xr[3]),
        .x4(xr[4]), .x5(xr[5]), .x6(xr[6]), .x7(xr[7]),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_on(lcd_on), .init_done(init_done), .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference display text: four "HH  " groups per line, uppercase hex
    function automatic string hex2(input logic [7:0] v);
        string h;
        h = "0123456789ABCDEF";
        return $sformatf("%c%c", h[int'(v[7:4])], h[int'(v[3:0])]);
    endfunction

    function automatic string line_text(input logic [7:0][7:0] xv, input int l);
        string s;
        s = "";
        for (int g = 0; g < 4; g++) s = {s, hex2(xv[4*l+g]), "  "};
        return s;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: records every write, checks setup/hold stability, pulse width and rw
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            pen = 1'b0;
            pid = 1'b0;
        end else begin
            chk("rw_low", 32'(lcd_rw), 32'd0);
            if (lcd_en && pen) begin
                chk("data_stable_en", 32'(lcd_data), 32'(pdata));
                chk("rs_stable_en", 32'(lcd_rs), 32'(prs));
            end
            if (lcd_en && !pen) begin
                chk("data_setup", 32'(lcd_data), 32'(ldata));
                chk("rs_setup", 32'(lcd_rs), 32'(lrs));
                rise_c = cyc;
                pdata  = lcd_data;
                prs    = lcd_rs;
            end
            if (!lcd_en && pen) begin
                chk("en_width", 32'(cyc - rise_c), 32'(ENC));
                wq.push_back('{prs, pdata, rise_c});
            end
            if (frame_done) fdq.push_back(cyc);
            if (init_done && !pid) id_rise = cyc;
            pen = lcd_en;
            pid = init_done;
        end
        ldata = lcd_data;
        lrs   = lcd_rs;
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_writes(input int n, input int budget, input string tag, output bit ok);
        int b;
        b = 0;
        while (wq.size() < n && b < budget) begin
            @(posedge clk);
            #2;
            b++;
        end
        ok = (wq.size() >= n);
        chk({tag, "_arrive"}, 32'(ok), 32'd1);
    endtask

    task automatic power_on_check(output int s_out);
        int   rel;
        bit   ok;
        wr_t  w;
        int   prev_fall;
        logic [7:0] cmds [4];
        cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
        wq.delete();
        fdq.delete();
        id_rise = -1;
        @(negedge clk);
        rel = cyc;
        rst = 1'b1;
        s_out = rel + IW + 2 + 3*WP + ENC + CLW;
        wait_cyc(rel + IW + 1);
        chk("pwr_no_pulse", 32'(wq.size()), 32'd0);
        chk("first_setup_en", 32'(lcd_en), 32'd0);
        chk("first_setup_data", 32'(lcd_data), 32'h38);
        prev_fall = 0;
        wait_writes(4, 60, "init", ok);
        if (ok) begin
            for (int k = 0; k < 4; k++) begin
                w = wq.pop_front();
                chk($sformatf("init%0d_rs", k), 32'(w.rs), 32'd0);
                chk($sformatf("init%0d_data", k), 32'(w.data), 32'(cmds[k]));
                chk($sformatf("init%0d_rise", k), 32'(w.rise), 32'(rel + IW + 2 + WP*k));
                if (k > 0) chk($sformatf("init%0d_gap", k), 32'(w.rise - prev_fall), 32'(1 + CW));
                prev_fall = w.rise + ENC;
            end
        end
        wait_cyc(s_out + 1);
        chk("init_done_cycle", 32'(id_rise), 32'(rel + IW + 2 + 3*WP + ENC + CLW));
        chk("init_done_level", 32'(init_done), 32'd1);
    endtask

    task automatic check_frame(input int s, input logic [7:0][7:0] xv, input string tag);
        string      l0, l1;
        logic       erd;
        logic [7:0] ed;
        wr_t        w;
        bit         ok;
        l0 = line_text(xv, 0);
        l1 = line_text(xv, 1);
        wait_writes(34, FP + 40, tag, ok);
        if (ok) begin
            for (int j = 0; j < 34; j++) begin
                if (j == 0) begin
                    erd = 1'b0; ed = 8'h80;
                end else if (j < 17) begin
                    erd = 1'b1; ed = l0[j-1];
                end else if (j == 17) begin
                    erd = 1'b0; ed = 8'hC0;
                end else begin
                    erd = 1'b1; ed = l1[j-18];
                end
                w = wq.pop_front();
                chk($sformatf("%s_w%0d_rs", tag, j), 32'(w.rs), 32'(erd));
                chk($sformatf("%s_w%0d_data", tag, j), 32'(w.data), 32'(ed));
                chk($sformatf("%s_w%0d_rise", tag, j), 32'(w.rise), 32'(s + 2 + WP*j));
            end
        end
        wait_cyc(s + FP);
        chk({tag, "_fd_count"}, 32'(fdq.size()), 32'd1);
        if (fdq.size() > 0) chk({tag, "_fd_cycle"}, 32'(fdq[0]), 32'(s + FB));
        fdq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int              s;
        int              b;
        logic [7:0][7:0] snap;
        xr  = '{8'h00, 8'h1F, 8'hA5, 8'hFF, 8'h3C, 8'h9B, 8'h07, 8'hE0};
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_data", 32'(lcd_data), 32'h00);
        chk("rst_rs", 32'(lcd_rs), 32'd0);
        chk("rst_rw", 32'(lcd_rw), 32'd0);
        chk("rst_en", 32'(lcd_en), 32'd0);
        chk("rst_on", 32'(lcd_on), 32'd1);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);

        power_on_check(s);
        snap = {xr[7], xr[6], xr[5], xr[4], xr[3], xr[2], xr[1], xr[0]};

        // Frame 0 fixed pattern; x2 changes mid-frame; later frames random
        for (int f = 0; f < 6; f++) begin
            wait_cyc(s + 30);
            if (f == 0) xr[2] = 8'h5A;
            else for (int i = 0; i < 8; i++) xr[i] = 8'($urandom);
            check_frame(s, snap, $sformatf("frame%0d", f));
            snap = {xr[7], xr[6], xr[5], xr[4], xr[3], xr[2], xr[1], xr[0]};
            s += FP;
        end

        b = 0;
        do begin
            @(posedge clk);
            #2;
            b++;
        end while (!(lcd_en && lcd_rs) && b < 300);
        chk("find_char_pulse", 32'({lcd_en, lcd_rs}), 32'd3);
        #1 rst = 1'b0;
        #1;
        chk("async_en", 32'(lcd_en), 32'd0);
        chk("async_rs", 32'(lcd_rs), 32'd0);
        chk("async_data", 32'(lcd_data), 32'h00);
        chk("async_init_done", 32'(init_done), 32'd0);
        repeat (3) @(posedge clk);

        power_on_check(s);
        snap = {xr[7], xr[6], xr[5], xr[4], xr[3], xr[2], xr[1], xr[0]};
        check_frame(s, snap, "post_reset");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
